if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Multi-entry instruction queue between fetch and decode. Each entry holds the instruction word, its address, the branch-prediction bit and the interrupt flags.
- Uses a valid/ready handshake on both sides, plus a pipeline-hold input and a flush input.
- Decouples fetch from decode stalls. Presents a NOP bubble to decode whenever it is empty or flushed.

Parameters:
DEPTH, 4, number of queue entries; any integer >= 2
INST_W, 32, instruction width
ADDR_W, 32, instruction-address width
INT_W, 8, interrupt-flag width
HOLD_W, 3, hold-flag bus width
HOLD_IF, 1, hold_flag_i value at or above which decode-side pops are blocked
NOP_INST, 32'h00000013, instruction presented when the queue is empty

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush_i  in  1  discard all entries (branch/jump/trap redirect)
hold_flag_i  in  HOLD_W  pipeline hold level
valid_i  in  1  fetch presents an entry
ready_o  out  1  queue can accept an entry
inst_i  in  INST_W  instruction
inst_addr_i  in  ADDR_W  instruction address
bp_result_i  in  1  predicted-taken bit
int_flag_i  in  INT_W  interrupt flags
valid_o  out  1  head entry valid
ready_i  in  1  decode consumes head
inst_o  out  INST_W  head instruction, or NOP_INST
inst_addr_o  out  ADDR_W  head address, or 0
bp_result_o  out  1  head prediction bit, or 0
int_flag_o  out  INT_W  head interrupt flags, or 0
count_o  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Everything is sampled on the rising edge of clk. rst=1 is synchronous and active-high and overrides all other inputs.
- Reset state: count=0, both pointers=0, valid_o=0, ready_o=1, inst_o=NOP_INST, inst_addr_o=0, bp_result_o=0, int_flag_o=0.
- Storage: circular buffer with rd_ptr and wr_ptr in the range 0..DEPTH-1.
  - Each pointer increments and wraps explicitly: at DEPTH-1 it goes to 0. No power-of-two assumption.
  - The occupancy counter is authoritative: empty when count==0, full when count==DEPTH.
- ready_o = (count != DEPTH), combinational from count.
  - ready_o does not depend on ready_i. A full queue refuses a push even in a cycle where it also pops.
- valid_o = (count != 0).
- Head outputs are driven from the entry at rd_ptr.
  - When count==0 they are forced to NOP_INST / 0 / 0 / 0.
  - Data never falls through: an entry pushed at edge N is first visible at the outputs after edge N.
- push = valid_i & ready_o & ~flush_i.
- pop = valid_o & ready_i & (hold_flag_i < HOLD_IF) & ~flush_i.
- Hold: when hold_flag_i >= HOLD_IF, the head entry and outputs are frozen. Pushes still proceed while not full.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Flush: at the edge, count=0 and rd_ptr=wr_ptr=0. Any push or pop in the same cycle is discarded. Outputs show the NOP bubble from the next cycle. Flush has priority over hold.
- Reset while operating: all entries are dropped, exactly as for flush. Stored payload data need not be cleared.
- Entry payloads are written only on push, so an entry is never corrupted while it is resident.
- count_o equals the internal count.

Test Plan:
- Reset -> valid_o=0, ready_o=1, inst_o=0x00000013, inst_addr_o=0, count_o=0.
- With DEPTH=4 and ready_i=0, push 0x00100093@0x0, 0x00200113@0x4, 0x00300193@0x8, 0x00400213@0xC -> count_o=4, ready_o=0. A 5th push is refused. Then ready_i=1 -> outputs appear in push order, one per cycle, the last is inst_addr_o=0xC, and the queue returns to count_o=0 with NOP outputs.
- Continuous push and pop at count=2 for 10 cycles, with addresses incrementing by 4 -> count_o stays 2, pointers wrap past 3 to 0, output address sequence is contiguous.
- hold_flag_i=1 for 3 cycles, ready_i=1, queue holding 1 entry, fetch pushing -> head inst_addr_o is unchanged for those 3 cycles and count_o rises to 4. After release, pops resume.
- flush_i=1 with count=3 and valid_i=1 in the same cycle -> next cycle count_o=0, valid_o=0, inst_o=0x00000013. The concurrent push is not stored.
- bp_result_i=1 and int_flag_i=0x05 on entry 2 only -> bp_result_o=1 and int_flag_o=0x05 appear only while entry 2 is at the head; all other head entries show 0.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: multi-entry instruction queue between fetch and decode.
// Valid/ready on both sides; shows a NOP bubble to decode whenever it is empty or flushed.
module if_id_queue #(
    parameter int                DEPTH    = 4,
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                INT_W    = 8,
    parameter int                HOLD_W   = 3,
    parameter int                HOLD_IF  = 1,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [HOLD_W-1:0]            hold_flag_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [INST_W-1:0]            inst_i,
    input  logic [ADDR_W-1:0]            inst_addr_i,
    input  logic                         bp_result_i,
    input  logic [INT_W-1:0]             int_flag_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [INST_W-1:0]            inst_o,
    output logic [ADDR_W-1:0]            inst_addr_o,
    output logic                         bp_result_o,
    output logic [INT_W-1:0]             int_flag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(HOLD_IF);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic              bp_mem   [DEPTH];
    logic [INT_W-1:0]  int_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic hold_active;
    logic push;
    logic pop;

    // Explicit wrap so that non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty       = (count == '0);
    assign ready_o     = (count != FULL_CNT);
    assign valid_o     = ~empty;
    assign hold_active = (hold_flag_i >= HOLD_LVL);

    assign push = valid_i & ready_o & ~flush_i;
    assign pop  = valid_o & ready_i & ~hold_active & ~flush_i;

    // Reset and flush both drop every resident entry; payloads are left as they are.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            inst_mem[wr_ptr] <= inst_i;
            addr_mem[wr_ptr] <= inst_addr_i;
            bp_mem[wr_ptr]   <= bp_result_i;
            int_mem[wr_ptr]  <= int_flag_i;
        end
    end

    // Head is read from storage only, so a new entry appears one edge after its push.
    assign inst_o      = empty ? NOP_INST   : inst_mem[rd_ptr];
    assign inst_addr_o = empty ? '0         : addr_mem[rd_ptr];
    assign bp_result_o = empty ? 1'b0       : bp_mem[rd_ptr];
    assign int_flag_o  = empty ? '0         : int_mem[rd_ptr];
    assign count_o     = count;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue at DEPTH=4.
// Exercises fill/drain, streaming with pointer wrap, hold, flush and mid-run reset.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [2:0]  hold_flag_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        bp_result_i;
    logic [7:0]  int_flag_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        bp_result_o;
    logic [7:0]  int_flag_o;
    logic [2:0]  count_o;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] fillInst [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

    if_id_queue #(
        .DEPTH(4), .INST_W(32), .ADDR_W(32), .INT_W(8),
        .HOLD_W(3), .HOLD_IF(1), .NOP_INST(32'h00000013)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .hold_flag_i(hold_flag_i),
        .valid_i(valid_i), .ready_o(ready_o), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .bp_result_i(bp_result_i), .int_flag_i(int_flag_i),
        .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .bp_result_o(bp_result_o), .int_flag_o(int_flag_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst,
                                 input logic [31:0] addr, input logic bp,
                                 input logic [7:0] intf, input logic rdy,
                                 input logic [2:0] hold, input logic fl);
        valid_i     = v;
        inst_i      = inst;
        inst_addr_i = addr;
        bp_result_i = bp;
        int_flag_i  = intf;
        ready_i     = rdy;
        hold_flag_i = hold;
        flush_i     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 0, 8'h00, 0, 3'd0, 0);
        tick();
        tick();
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_inst",  inst_o, NOP);
        checkOutput("rst_addr",  inst_addr_o, 32'h0);
        checkOutput("rst_bp",    32'(bp_result_o), 32'd0);
        checkOutput("rst_int",   32'(int_flag_o), 32'd0);
        checkOutput("rst_count", 32'(count_o), 32'd0);
        rst = 1'b0;

        // Fill to full with decode stalled; entry 2 carries bp and interrupt flags.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, fillInst[i], 32'(4 * i), (i == 2), (i == 2) ? 8'h05 : 8'h00,
                          0, 3'd0, 0);
            if (i == 0) begin
                checkOutput("no_fallthrough_valid", 32'(valid_o), 32'd0);
                checkOutput("no_fallthrough_inst", inst_o, NOP);
            end
            tick();
        end
        checkOutput("full_count", 32'(count_o), 32'd4);
        checkOutput("full_ready", 32'(ready_o), 32'd0);
        checkOutput("full_head",  inst_o, fillInst[0]);

        applyStimulus(1, 32'h00500293, 32'h10, 0, 8'h00, 0, 3'd0, 0);
        tick();
        checkOutput("refused_count", 32'(count_o), 32'd4);
        checkOutput("refused_head_addr", inst_addr_o, 32'h0);

        applyStimulus(0, 32'h0, 32'h0, 0, 8'h00, 1, 3'd0, 0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_valid", 32'(valid_o), 32'd1);
            checkOutput("drain_inst", inst_o, fillInst[k]);
            checkOutput("drain_addr", inst_addr_o, 32'(4 * k));
            checkOutput("drain_bp",   32'(bp_result_o), (k == 2) ? 32'd1 : 32'd0);
            checkOutput("drain_int",  32'(int_flag_o), (k == 2) ? 32'h05 : 32'h00);
            tick();
        end
        checkOutput("drained_count", 32'(count_o), 32'd0);
        checkOutput("drained_valid", 32'(valid_o), 32'd0);
        checkOutput("drained_inst",  inst_o, NOP);
        checkOutput("drained_addr",  inst_addr_o, 32'h0);
        checkOutput("drained_ready", 32'(ready_o), 32'd1);

        // Prime two entries, then stream push+pop so the pointers wrap several times.
        applyStimulus(1, 32'h00000093, 32'h100, 0, 8'h00, 0, 3'd0, 0);
        tick();
        applyStimulus(1, 32'h00000093, 32'h104, 0, 8'h00, 0, 3'd0, 0);
        tick();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 32'h00000093, 32'(32'h108 + 4 * c), 0, 8'h00, 1, 3'd0, 0);
            checkOutput("stream_addr",  inst_addr_o, 32'(32'h100 + 4 * c));
            checkOutput("stream_count", 32'(count_o), 32'd2);
            tick();
        end
        checkOutput("stream_end_count", 32'(count_o), 32'd2);
        checkOutput("stream_end_addr",  inst_addr_o, 32'h128);
        applyStimulus(0, 32'h0, 32'h0, 0, 8'h00, 1, 3'd0, 0);
        tick();
        tick();
        checkOutput("stream_drained", 32'(count_o), 32'd0);

        // Hold freezes the head while fetch keeps filling the queue.
        applyStimulus(1, 32'h00000113, 32'h200, 0, 8'h00, 0, 3'd0, 0);
        tick();
        for (int h = 0; h < 3; h++) begin
            applyStimulus(1, 32'h00000113, 32'(32'h204 + 4 * h), 0, 8'h00, 1,
                          (h == 2) ? 3'd3 : 3'd1, 0);
            checkOutput("hold_addr", inst_addr_o, 32'h200);
            tick();
        end
        checkOutput("hold_count", 32'(count_o), 32'd4);
        checkOutput("hold_addr_after", inst_addr_o, 32'h200);
        checkOutput("hold_ready", 32'(ready_o), 32'd0);
        applyStimulus(0, 32'h0, 32'h0, 0, 8'h00, 1, 3'd0, 0);
        tick();
        checkOutput("release_addr",  inst_addr_o, 32'h204);
        checkOutput("release_count", 32'(count_o), 32'd3);

        // Flush with a concurrent push at count 3.
        applyStimulus(1, 32'h00000193, 32'h300, 0, 8'h00, 1, 3'd0, 1);
        tick();
        checkOutput("flush_count", 32'(count_o), 32'd0);
        checkOutput("flush_valid", 32'(valid_o), 32'd0);
        checkOutput("flush_inst",  inst_o, NOP);
        checkOutput("flush_addr",  inst_addr_o, 32'h0);
        applyStimulus(0, 32'h0, 32'h0, 0, 8'h00, 0, 3'd0, 0);
        tick();
        checkOutput("flush_push_dropped", 32'(count_o), 32'd0);

        applyStimulus(1, 32'h00500293, 32'h400, 0, 8'h00, 0, 3'd0, 0);
        tick();
        checkOutput("post_flush_count", 32'(count_o), 32'd1);
        checkOutput("post_flush_addr",  inst_addr_o, 32'h400);
        checkOutput("post_flush_inst",  inst_o, 32'h00500293);

        // Reset in mid-operation drops entries and ignores the concurrent push.
        rst = 1'b1;
        applyStimulus(1, 32'h00600313, 32'h404, 0, 8'h00, 0, 3'd0, 0);
        tick();
        checkOutput("midrst_count", 32'(count_o), 32'd0);
        checkOutput("midrst_valid", 32'(valid_o), 32'd0);
        checkOutput("midrst_ready", 32'(ready_o), 32'd1);
        checkOutput("midrst_inst",  inst_o, NOP);
        rst = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 0, 8'h00, 0, 3'd0, 0);
        tick();
        checkOutput("after_rst_count", 32'(count_o), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
